at_pipe_tracker: RTL and testbench



---
 rtl/at_pipe_tracker_pkg.sv | 28 ++
 rtl/at_pipe_tracker_slot.sv | 94 +++++++++
 rtl/at_pipe_tracker.sv | 101 ++++++++++
 tb/tb_at_pipe_tracker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/at_pipe_tracker_pkg.sv
// Shared definitions for the E/M/W hazard-information pipeline:
// default widths, T_new encodings and the bubble value of a slot.
package at_pipe_tracker_pkg;

   localparam int REG_W_DEF  = 5;
   localparam int TNEW_W_DEF = 2;
   localparam int CNT_W_DEF  = 32;

   // Remaining result latency as seen on entry to E
   localparam int TNEW_LW   = 2;
   localparam int TNEW_ALU  = 1;
   localparam int TNEW_ZERO = 0;

   // One slot at default widths; a bubble is every field cleared
   typedef struct packed {
      logic [REG_W_DEF-1:0]  rs;
      logic [REG_W_DEF-1:0]  rt;
      logic [REG_W_DEF-1:0]  wreg;
      logic                  grf_we;
      logic                  is_lw;
      logic                  is_sw;
      logic [TNEW_W_DEF-1:0] t_new;
   } slot_t;

   localparam slot_t BUBBLE     = '0;
   localparam logic  BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/at_pipe_tracker_slot.sv
// One registered hazard-info slot. Loads its inputs or a bubble each cycle;
// T_new can be stored as-is, stored after a saturating decrement, or not
// stored at all (the W slot, where T_new is always 0).
module at_stage_slot
   import at_pipe_tracker_pkg::*;
#(
   parameter int REG_W    = REG_W_DEF,
   parameter int TNEW_W   = TNEW_W_DEF,
   parameter bit HAS_TNEW = 1'b1,
   parameter bit DEC_TNEW = 1'b0
) (
   input  logic              clk,
   input  logic              i_srst,
   input  logic              i_bubble,
   input  logic [REG_W-1:0]  i_rs,
   input  logic [REG_W-1:0]  i_rt,
   input  logic [REG_W-1:0]  i_wreg,
   input  logic              i_we,
   input  logic              i_is_lw,
   input  logic              i_is_sw,
   input  logic [TNEW_W-1:0] i_t_new,
   output logic [REG_W-1:0]  o_rs,
   output logic [REG_W-1:0]  o_rt,
   output logic [REG_W-1:0]  o_wreg,
   output logic              o_we,
   output logic              o_is_lw,
   output logic              o_is_sw,
   output logic [TNEW_W-1:0] o_t_new
);

   logic [REG_W-1:0] r_rs;
   logic [REG_W-1:0] r_rt;
   logic [REG_W-1:0] r_wreg;
   logic             r_we;
   logic             r_is_lw;
   logic             r_is_sw;

   // Capture the incoming instruction, or clear to a bubble on reset/stall
   always_ff @(posedge clk) begin
      if (i_srst || i_bubble) begin
         r_rs    <= {REG_W{BUBBLE_BIT}};
         r_rt    <= {REG_W{BUBBLE_BIT}};
         r_wreg  <= {REG_W{BUBBLE_BIT}};
         r_we    <= BUBBLE_BIT;
         r_is_lw <= BUBBLE_BIT;
         r_is_sw <= BUBBLE_BIT;
      end else begin
         r_rs    <= i_rs;
         r_rt    <= i_rt;
         r_wreg  <= i_wreg;
         r_we    <= i_we;
         r_is_lw <= i_is_lw;
         r_is_sw <= i_is_sw;
      end
   end

   assign o_rs    = r_rs;
   assign o_rt    = r_rt;
   assign o_wreg  = r_wreg;
   assign o_we    = r_we;
   assign o_is_lw = r_is_lw;
   assign o_is_sw = r_is_sw;

   generate
      if (HAS_TNEW) begin : g_tnew
         logic [TNEW_W-1:0] w_t_next;
         logic [TNEW_W-1:0] r_t_new;

         // Saturating decrement: a result already available stays at 0
         always_comb begin
            w_t_next = i_t_new;
            if (DEC_TNEW && (i_t_new != TNEW_W'(TNEW_ZERO))) begin
               w_t_next = i_t_new - TNEW_W'(1);
            end
         end

         // Remaining-latency register, cleared with the rest of the slot
         always_ff @(posedge clk) begin
            if (i_srst || i_bubble) begin
               r_t_new <= TNEW_W'(TNEW_ZERO);
            end else begin
               r_t_new <= w_t_next;
            end
         end

         assign o_t_new = r_t_new;
      end else begin : g_no_tnew
         logic w_unused_t_new;
         assign w_unused_t_new = ^i_t_new;
         assign o_t_new        = TNEW_W'(TNEW_ZERO);
      end
   endgenerate

endmodule

// File: rtl/at_pipe_tracker.sv
// Producer side of the stall/forwarding interface: walks each decoded
// instruction's hazard info through E, M and W, bubbling E on stall and
// counting inserted bubbles.
module at_pipe_tracker
   import at_pipe_tracker_pkg::*;
#(
   parameter int REG_W  = REG_W_DEF,
   parameter int TNEW_W = TNEW_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [REG_W-1:0]  D_rs,
   input  logic [REG_W-1:0]  D_rt,
   input  logic [REG_W-1:0]  D_Wreg,
   input  logic              D_GRF_WE,
   input  logic              D_is_LW,
   input  logic              D_is_SW,
   input  logic [TNEW_W-1:0] D_T_new,
   output logic [REG_W-1:0]  E_rs,
   output logic [REG_W-1:0]  E_rt,
   output logic [REG_W-1:0]  M_rs,
   output logic [REG_W-1:0]  M_rt,
   output logic [REG_W-1:0]  W_rs,
   output logic [REG_W-1:0]  W_rt,
   output logic [REG_W-1:0]  E_Wreg,
   output logic [REG_W-1:0]  M_Wreg,
   output logic [REG_W-1:0]  W_Wreg,
   output logic              E_GRF_WE,
   output logic              M_GRF_WE,
   output logic              W_GRF_WE,
   output logic              E_is_LW,
   output logic              E_is_SW,
   output logic              M_is_LW,
   output logic              M_is_SW,
   output logic              W_is_LW,
   output logic [TNEW_W-1:0] E_T_new,
   output logic [TNEW_W-1:0] M_T_new,
   output logic [CNT_W-1:0]  stall_cnt
);

   // A $0 destination must never look like a producer downstream
   logic              w_d_wreg_nz;
   logic              w_d_we;
   logic [TNEW_W-1:0] w_d_t_new;

   assign w_d_wreg_nz = (D_Wreg != '0);
   assign w_d_we      = D_GRF_WE & w_d_wreg_nz;
   assign w_d_t_new   = w_d_wreg_nz ? D_T_new : TNEW_W'(TNEW_ZERO);

   // W carries no T_new and no store flag to the outside
   logic [TNEW_W-1:0] w_w_t_new;
   logic              w_w_is_sw;
   logic              w_unused_w;
   assign w_unused_w = ^{w_w_t_new, w_w_is_sw};

   at_stage_slot #(
      .REG_W(REG_W), .TNEW_W(TNEW_W), .HAS_TNEW(1'b1), .DEC_TNEW(1'b0)
   ) u_slot_e (
      .clk(clk), .i_srst(reset), .i_bubble(stall),
      .i_rs(D_rs), .i_rt(D_rt), .i_wreg(D_Wreg), .i_we(w_d_we),
      .i_is_lw(D_is_LW), .i_is_sw(D_is_SW), .i_t_new(w_d_t_new),
      .o_rs(E_rs), .o_rt(E_rt), .o_wreg(E_Wreg), .o_we(E_GRF_WE),
      .o_is_lw(E_is_LW), .o_is_sw(E_is_SW), .o_t_new(E_T_new)
   );

   at_stage_slot #(
      .REG_W(REG_W), .TNEW_W(TNEW_W), .HAS_TNEW(1'b1), .DEC_TNEW(1'b1)
   ) u_slot_m (
      .clk(clk), .i_srst(reset), .i_bubble(1'b0),
      .i_rs(E_rs), .i_rt(E_rt), .i_wreg(E_Wreg), .i_we(E_GRF_WE),
      .i_is_lw(E_is_LW), .i_is_sw(E_is_SW), .i_t_new(E_T_new),
      .o_rs(M_rs), .o_rt(M_rt), .o_wreg(M_Wreg), .o_we(M_GRF_WE),
      .o_is_lw(M_is_LW), .o_is_sw(M_is_SW), .o_t_new(M_T_new)
   );

   at_stage_slot #(
      .REG_W(REG_W), .TNEW_W(TNEW_W), .HAS_TNEW(1'b0), .DEC_TNEW(1'b0)
   ) u_slot_w (
      .clk(clk), .i_srst(reset), .i_bubble(1'b0),
      .i_rs(M_rs), .i_rt(M_rt), .i_wreg(M_Wreg), .i_we(M_GRF_WE),
      .i_is_lw(M_is_LW), .i_is_sw(M_is_SW), .i_t_new(M_T_new),
      .o_rs(W_rs), .o_rt(W_rt), .o_wreg(W_Wreg), .o_we(W_GRF_WE),
      .o_is_lw(W_is_LW), .o_is_sw(w_w_is_sw), .o_t_new(w_w_t_new)
   );

   logic [CNT_W-1:0] r_stall_cnt;

   // Count inserted bubbles; reset takes priority over a coincident stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (stall) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_at_pipe_tracker.sv
// Bench for at_pipe_tracker: directed scenarios plus a randomized run,
// all checked against a delay-line model of the E/M/W slots.
module tb_at_pipe_tracker;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wreg;
      logic       we;
      logic       lw;
      logic       sw;
      logic [1:0] t;
   } ent_t;

   localparam ent_t BUB = '0;

   logic        clk = 1'b0;
   logic        reset, stall;
   logic [4:0]  D_rs, D_rt, D_Wreg;
   logic        D_GRF_WE, D_is_LW, D_is_SW;
   logic [1:0]  D_T_new;
   logic [4:0]  E_rs, E_rt, M_rs, M_rt, W_rs, W_rt;
   logic [4:0]  E_Wreg, M_Wreg, W_Wreg;
   logic        E_GRF_WE, M_GRF_WE, W_GRF_WE;
   logic        E_is_LW, E_is_SW, M_is_LW, M_is_SW, W_is_LW;
   logic [1:0]  E_T_new, M_T_new;
   logic [31:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   at_pipe_tracker dut (
      .clk(clk), .reset(reset), .stall(stall),
      .D_rs(D_rs), .D_rt(D_rt), .D_Wreg(D_Wreg), .D_GRF_WE(D_GRF_WE),
      .D_is_LW(D_is_LW), .D_is_SW(D_is_SW), .D_T_new(D_T_new),
      .E_rs(E_rs), .E_rt(E_rt), .M_rs(M_rs), .M_rt(M_rt), .W_rs(W_rs), .W_rt(W_rt),
      .E_Wreg(E_Wreg), .M_Wreg(M_Wreg), .W_Wreg(W_Wreg),
      .E_GRF_WE(E_GRF_WE), .M_GRF_WE(M_GRF_WE), .W_GRF_WE(W_GRF_WE),
      .E_is_LW(E_is_LW), .E_is_SW(E_is_SW), .M_is_LW(M_is_LW), .M_is_SW(M_is_SW),
      .W_is_LW(W_is_LW), .E_T_new(E_T_new), .M_T_new(M_T_new), .stall_cnt(stall_cnt)
   );

   ent_t obs_e, obs_m, obs_w;
   assign obs_e = {E_rs, E_rt, E_Wreg, E_GRF_WE, E_is_LW, E_is_SW, E_T_new};
   assign obs_m = {M_rs, M_rt, M_Wreg, M_GRF_WE, M_is_LW, M_is_SW, M_T_new};
   assign obs_w = {W_rs, W_rt, W_Wreg, W_GRF_WE, W_is_LW, 1'b0, 2'b00};

   // Model: hist[k] is what entered E k cycles ago; M and W are just older entries
   ent_t        hist[$] = '{BUB, BUB, BUB};
   logic [31:0] exp_cnt = 0;
   ent_t        exp_e, exp_m, exp_w;

   function automatic ent_t cur_d();
      ent_t d;
      d = {D_rs, D_rt, D_Wreg, D_GRF_WE, D_is_LW, D_is_SW, D_T_new};
      if (d.wreg == 0) begin
         d.we = 1'b0;
         d.t  = 2'd0;
      end
      return d;
   endfunction

   task automatic model_step();
      if (reset) begin
         hist    = '{BUB, BUB, BUB};
         exp_cnt = 0;
      end else begin
         hist.push_front(stall ? BUB : cur_d());
         void'(hist.pop_back());
         if (stall) exp_cnt = exp_cnt + 1;
      end
      exp_e   = hist[0];
      exp_m   = hist[1];
      exp_m.t = (hist[1].t == 0) ? 2'd0 : hist[1].t - 2'd1;
      exp_w    = hist[2];
      exp_w.sw = 1'b0;
      exp_w.t  = 2'd0;
   endtask

   task automatic drive(input logic rst, input logic stl, input ent_t d);
      reset    = rst;
      stall    = stl;
      D_rs     = d.rs;
      D_rt     = d.rt;
      D_Wreg   = d.wreg;
      D_GRF_WE = d.we;
      D_is_LW  = d.lw;
      D_is_SW  = d.sw;
      D_T_new  = d.t;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   function automatic ent_t rand_ent();
      return ent_t'($urandom);
   endfunction

   task automatic test_reset();
      drive(1'b1, 1'($urandom), rand_ent());
      tick();
      total++;
      if ({obs_e, obs_m, obs_w} !== '0) begin
         bad++;
         $display("FAIL reset_slots: got E=%h M=%h W=%h required all 0", obs_e, obs_m, obs_w);
      end
      total++;
      if (stall_cnt !== 32'd0) begin
         bad++;
         $display("FAIL reset_cnt: got %0d required 0", stall_cnt);
      end
      $display("reset: E=%h M=%h W=%h cnt=%0d", obs_e, obs_m, obs_w, stall_cnt);
   endtask

   task automatic test_lw_walk();
      ent_t lw;
      lw = '{rs: 5'd3, rt: 5'd8, wreg: 5'd8, we: 1'b1, lw: 1'b1, sw: 1'b0, t: 2'd2};
      drive(1'b0, 1'b0, lw);
      tick();
      total++;
      if (E_Wreg !== 5'd8 || E_T_new !== 2'd2 || E_is_LW !== 1'b1) begin
         bad++;
         $display("FAIL lw_e: got Wreg=%0d T=%0d lw=%b required 8 2 1", E_Wreg, E_T_new, E_is_LW);
      end
      $display("lw E: Wreg=%0d T_new=%0d", E_Wreg, E_T_new);
      drive(1'b0, 1'b0, rand_ent());
      tick();
      total++;
      if (M_Wreg !== 5'd8 || M_T_new !== 2'd1) begin
         bad++;
         $display("FAIL lw_m: got Wreg=%0d T=%0d required 8 1", M_Wreg, M_T_new);
      end
      $display("lw M: Wreg=%0d T_new=%0d", M_Wreg, M_T_new);
      drive(1'b0, 1'b0, rand_ent());
      tick();
      total++;
      if (W_Wreg !== 5'd8 || W_is_LW !== 1'b1 || W_GRF_WE !== 1'b1) begin
         bad++;
         $display("FAIL lw_w: got Wreg=%0d lw=%b we=%b required 8 1 1", W_Wreg, W_is_LW, W_GRF_WE);
      end
      $display("lw W: Wreg=%0d is_LW=%b", W_Wreg, W_is_LW);
   endtask

   task automatic test_stall_bubble();
      ent_t addu;
      addu = '{rs: 5'd4, rt: 5'd5, wreg: 5'd9, we: 1'b1, lw: 1'b0, sw: 1'b0, t: 2'd1};
      drive(1'b0, 1'b0, addu);
      tick();
      drive(1'b0, 1'b1, rand_ent());
      tick();
      total++;
      if (obs_e !== BUB) begin
         bad++;
         $display("FAIL stall_e_bubble: got %h required 0", obs_e);
      end
      total++;
      if (M_Wreg !== 5'd9 || M_T_new !== 2'd0 || M_GRF_WE !== 1'b1) begin
         bad++;
         $display("FAIL stall_m_kept: got Wreg=%0d T=%0d we=%b required 9 0 1", M_Wreg, M_T_new, M_GRF_WE);
      end
      total++;
      if (stall_cnt !== 32'd1) begin
         bad++;
         $display("FAIL stall_cnt: got %0d required 1", stall_cnt);
      end
      $display("stall: E=%h M_Wreg=%0d cnt=%0d", obs_e, M_Wreg, stall_cnt);
   endtask

   task automatic test_zero_sanitise();
      ent_t z;
      z = '{rs: 5'd1, rt: 5'd2, wreg: 5'd0, we: 1'b1, lw: 1'b0, sw: 1'b0, t: 2'd1};
      drive(1'b0, 1'b0, z);
      tick();
      total++;
      if (E_GRF_WE !== 1'b0 || E_T_new !== 2'd0 || E_rs !== 5'd1 || E_rt !== 5'd2) begin
         bad++;
         $display("FAIL zero_sanitise: got we=%b T=%0d rs=%0d rt=%0d required 0 0 1 2",
                  E_GRF_WE, E_T_new, E_rs, E_rt);
      end
      $display("sanitise: E_GRF_WE=%b E_T_new=%0d", E_GRF_WE, E_T_new);
   endtask

   task automatic test_saturation();
      ent_t jal;
      jal = '{rs: 5'd0, rt: 5'd0, wreg: 5'd31, we: 1'b1, lw: 1'b0, sw: 1'b0, t: 2'd0};
      drive(1'b0, 1'b0, jal);
      tick();
      total++;
      if (E_Wreg !== 5'd31 || E_T_new !== 2'd0) begin
         bad++;
         $display("FAIL sat_e: got Wreg=%0d T=%0d required 31 0", E_Wreg, E_T_new);
      end
      drive(1'b0, 1'b0, rand_ent());
      tick();
      total++;
      if (M_Wreg !== 5'd31 || M_T_new !== 2'd0) begin
         bad++;
         $display("FAIL sat_m: got Wreg=%0d T=%0d required 31 0", M_Wreg, M_T_new);
      end
      $display("saturate: M_Wreg=%0d M_T_new=%0d", M_Wreg, M_T_new);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(99) < 3), ($urandom_range(99) < 30), rand_ent());
         tick();
         total++;
         if (obs_e !== exp_e || obs_m !== exp_m || obs_w !== exp_w || stall_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL random[%0d]: got E=%h M=%h W=%h cnt=%0d required E=%h M=%h W=%h cnt=%0d",
                     i, obs_e, obs_m, obs_w, stall_cnt, exp_e, exp_m, exp_w, exp_cnt);
         end
         $display("rand %0d: rst=%b stall=%b E=%h M=%h W=%h cnt=%0d",
                  i, reset, stall, obs_e, obs_m, obs_w, stall_cnt);
      end
   endtask

   task automatic test_reset_vs_stall();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, rand_ent());
         tick();
      end
      total++;
      if (stall_cnt !== exp_cnt || obs_e !== BUB) begin
         bad++;
         $display("FAIL back_to_back: got cnt=%0d E=%h required cnt=%0d E=0", stall_cnt, obs_e, exp_cnt);
      end
      $display("5 stalls: cnt=%0d", stall_cnt);
      drive(1'b1, 1'b1, rand_ent());
      tick();
      total++;
      if (stall_cnt !== 32'd0 || {obs_e, obs_m, obs_w} !== '0) begin
         bad++;
         $display("FAIL reset_vs_stall: got cnt=%0d E=%h M=%h W=%h required all 0",
                  stall_cnt, obs_e, obs_m, obs_w);
      end
      $display("reset+stall: cnt=%0d E=%h M=%h W=%h", stall_cnt, obs_e, obs_m, obs_w);
   endtask

   initial begin
      drive(1'b1, 1'b0, BUB);
      test_reset();
      test_lw_walk();
      test_stall_bubble();
      test_zero_sanitise();
      test_saturation();
      test_random();
      drive(1'b0, 1'b0, rand_ent());
      tick();
      test_reset_vs_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
